div_unit: RTL and testbench

- Iterative 32-bit divider that answers divide requests from the multicycle control FSM.
- Control pulses start with operands from register A/B; the block runs one restoring-division step per cycle and returns quotient/remainder for the HI/LO write.
- Returns a one-cycle done and a divide-by-zero flag; control uses the flag to raise the Div0 exception.
- Sits beside the ALU in the datapath; control owns the HILOWrite decision.

---
 rtl/div_unit.sv | 146 ++++++++++++++
 tb/tb_div_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Purpose : iterative signed (optionally unsigned) WIDTH-bit restoring divider for HI/LO writes.
// Latency : done pulses 34 cycles after an accepted start (1 load + WIDTH steps + 1 fix);
//           a zero divisor pulses done/div0 one cycle after start.
// Backpres: start is only honoured in IDLE; while busy, start and the operands are ignored.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   start             one-cycle request, sampled only while idle
//   dividend, divisor operands, sampled with start
//   is_unsigned       (only when DIVU_EN is defined) treat operands as unsigned (divu)
//   busy              high while a division is running (RUN or FIX)
//   done              one-cycle completion pulse (result valid or div0)
//   div0              divide-by-zero flag, held until the next accepted start
//   hi, lo            remainder, quotient; hold their value between operations
//
// Optional feature macro: DIVU_EN (adds the is_unsigned port).

module div_unit #(
  parameter int WIDTH = 32,
  parameter int STEPS = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIVU_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] quot;   // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH:0]   rem;    // partial remainder
  logic [WIDTH-1:0] dvs;    // divisor magnitude
  logic [CW-1:0]    cnt;
  logic             neg_q;  // negate quotient at the end
  logic             neg_r;  // negate remainder at the end

  // Operand conditioning for the load cycle.
  logic             signed_req;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

`ifdef DIVU_EN
  assign signed_req = ~is_unsigned;
`else
  assign signed_req = 1'b1;
`endif

  // The most negative dividend maps onto itself, which read as unsigned is
  // exactly its magnitude, so the overflow case needs no special handling.
  assign dvd_abs = (signed_req && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
  assign dvs_abs = (signed_req && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

  // One restoring step: shift {rem,quot} left and try subtracting the divisor.
  // Computed one bit wider than rem so the borrow shows up as the sign bit.
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;

  assign rem_sh = {rem, quot[WIDTH-1]};
  assign trial  = rem_sh - {2'b00, dvs};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      div0  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      quot  <= '0;
      rem   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              // Report immediately; the result registers keep their old contents.
              div0 <= 1'b1;
              done <= 1'b1;
            end else begin
              div0  <= 1'b0;
              quot  <= dvd_abs;
              dvs   <= dvs_abs;
              rem   <= '0;
              cnt   <= '0;
              neg_q <= signed_req & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r <= signed_req & dividend[WIDTH-1];
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (trial[WIDTH+1]) begin
            rem  <= rem_sh[WIDTH:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
          end else begin
            rem  <= trial[WIDTH:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end

        FIX: begin
          // Quotient sign follows the operand signs; remainder follows the dividend.
          lo    <= neg_q ? (~quot + 1'b1) : quot;
          hi    <= neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Purpose : self-checking bench for div_unit against an arithmetic reference model.
// Latency : expects done 34 edges after an accepted start, 1 edge after a zero divisor.
// Backpres: exercises starts issued while busy and starts issued alongside done.

module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
`ifdef DIVU_EN
  logic        is_unsigned;
`endif
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  // Architectural view of the result registers, tracked by the bench.
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  div_unit #(.WIDTH(32), .STEPS(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
`ifdef DIVU_EN
    .is_unsigned (is_unsigned),
`endif
    .busy     (busy),
    .done     (done),
    .div0     (div0),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: MIPS div/divu semantics via 64-bit integer arithmetic
  // (truncating division, remainder takes the dividend's sign).
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic u, output logic [31:0] q,
                                output logic [31:0] r);
    longint sa, sb, sq, sr;
    if (u) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end
    sq = sa / sb;
    sr = sa % sb;
    q  = sq[31:0];
    r  = sr[31:0];
  endfunction

  // Drive one start pulse; returns just after the sampling edge (edge N + 1 time unit).
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic u);
    dividend = a;
    divisor  = b;
`ifdef DIVU_EN
    is_unsigned = u;
`else
    if (u) $display("note: unsigned request issued in a signed-only build");
`endif
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Count edges (edge N counts as 1) until done is seen, bounded at 100.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 1;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIVU_EN
    is_unsigned = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    exp_hi = '0;
    exp_lo = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0 got %b exp 0", div0); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
  endtask

  // Full operation with latency, busy-length and result checks.
  task automatic run_check(input string name, input logic [31:0] a,
                           input logic [31:0] b, input logic u);
    int lat, bn;
    logic [31:0] q, r;
    model(a, b, u, q, r);
    launch(a, b, u);
    wait_done(lat, bn);
    exp_lo = q;
    exp_hi = r;
    checks++; if (lat !== 34) begin errors++; $display("FAIL %s_latency got %0d exp 34", name, lat); end
    checks++; if (bn !== 33) begin errors++; $display("FAIL %s_busy_cycles got %0d exp 33", name, bn); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s_lo a=%h b=%h got %h exp %h", name, a, b, lo, exp_lo); end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s_hi a=%h b=%h got %h exp %h", name, a, b, hi, exp_hi); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL %s_div0 got %b exp 0", name, div0); end
    @(posedge clock);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b exp 0", name, done); end
  endtask

  task automatic test_basic;
    run_check("pos", 32'd100, 32'd7, 1'b0);
    run_check("neg", 32'hFFFF_FF9C, 32'd7, 1'b0);
    run_check("negdvs", 32'd100, 32'hFFFF_FFF9, 1'b0);
  endtask

  task automatic test_div0;
    launch(32'd5, 32'd0, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL div0_done got %b exp 1", done); end
    checks++; if (div0 !== 1'b1) begin errors++; $display("FAIL div0_flag got %b exp 1", div0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div0_busy got %b exp 0", busy); end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL div0_hi_hold got %h exp %h", hi, exp_hi); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL div0_lo_hold got %h exp %h", lo, exp_lo); end
    @(posedge clock);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL div0_done_clear got %b exp 0", done); end
    checks++; if (div0 !== 1'b1) begin errors++; $display("FAIL div0_sticky got %b exp 1", div0); end
    // A second zero divisor keeps the flag up and pulses done again.
    launch(32'd9, 32'd0, 1'b0);
    checks++; if (div0 !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL div0_again got div0=%b done=%b exp 1 1", div0, done); end
    @(posedge clock);
    #1;
    // The next accepted start clears the flag at its sampling edge.
    launch(32'd50, 32'd6, 1'b0);
    checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL div0_clear got %b exp 0", div0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div0_next_busy got %b exp 1", busy); end
    begin
      int lat, bn;
      wait_done(lat, bn);
      exp_lo = 32'd8;
      exp_hi = 32'd2;
      checks++; if (lat !== 34) begin errors++; $display("FAIL div0_next_latency got %0d exp 34", lat); end
      checks++; if (lo !== exp_lo || hi !== exp_hi) begin errors++; $display("FAIL div0_next_result got %h/%h exp %h/%h", lo, hi, exp_lo, exp_hi); end
    end
    @(posedge clock);
    #1;
  endtask

  // Overflow case plus a start with different operands issued mid-run.
  task automatic test_overflow_ignore;
    int lat, bn;
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    dividend = 32'd123;
    divisor  = 32'd0;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    checks++; if (div0 !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL busy_start_ignored got div0=%b done=%b exp 0 0", div0, done); end
    wait_done(lat, bn);
    exp_lo = 32'h8000_0000;
    exp_hi = 32'd0;
    checks++; if (lat !== 29) begin errors++; $display("FAIL ovf_latency got %0d exp 29", lat); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL ovf_lo got %h exp %h", lo, exp_lo); end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL ovf_hi got %h exp %h", hi, exp_hi); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL ovf_div0 got %b exp 0", div0); end
  endtask

  // A start issued in the cycle where done is high is accepted.
  task automatic test_back_to_back;
    int lat, bn;
    logic [31:0] q, r;
    launch(32'd1000, 32'd33, 1'b0);
    wait_done(lat, bn);
    checks++; if (lo !== 32'd30 || hi !== 32'd10) begin errors++; $display("FAIL b2b_first got %h/%h exp 1e/a", lo, hi); end
    model(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, q, r);
    launch(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp 1", busy); end
    wait_done(lat, bn);
    exp_lo = q;
    exp_hi = r;
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got %0d exp 34", lat); end
    checks++; if (lo !== exp_lo || hi !== exp_hi) begin errors++; $display("FAIL b2b_second got %h/%h exp %h/%h", lo, hi, exp_lo, exp_hi); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      int mode;
      mode = $urandom_range(0, 5);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 31);
      case (mode)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: b = $urandom;
        default: b = 32'($urandom) >> $urandom_range(0, 31);
      endcase
      if (b == 32'd0) begin
        launch(a, b, 1'b0);
        checks++; if (done !== 1'b1 || div0 !== 1'b1) begin errors++; $display("FAIL rnd_div0 got done=%b div0=%b exp 1 1", done, div0); end
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++; $display("FAIL rnd_div0_hold got %h/%h exp %h/%h", lo, hi, exp_lo, exp_hi); end
        @(posedge clock);
        #1;
      end else begin
        run_check("rnd", a, b, 1'b0);
      end
    end
  endtask

  // Asynchronous reset while the counter is at 10 aborts the division.
  task automatic test_reset_mid;
    int seen;
    launch(32'd100, 32'd7, 1'b0);
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || div0 !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b done=%b div0=%b exp 0 0 0", busy, done, div0); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midrst_regs got %h/%h exp 0/0", lo, hi); end
    @(posedge clock);
    #3;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles exp 0", seen); end
  endtask

`ifdef DIVU_EN
  task automatic test_unsigned;
    run_check("divu", 32'hFFFF_FFFF, 32'd2, 1'b1);
    checks++; if (lo !== 32'h7FFF_FFFF || hi !== 32'd1) begin errors++; $display("FAIL divu_const got %h/%h exp 7fffffff/1", lo, hi); end
    run_check("divs_same", 32'hFFFF_FFFF, 32'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = 32'($urandom) >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd3;
      run_check("divu_rnd", a, b, 1'b1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div0();
    test_overflow_ignore();
    test_back_to_back();
    test_random();
`ifdef DIVU_EN
    test_unsigned();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
